// File: rtl/vga_pkg.sv
// Shared raster timing for the 640x480@60 display: default phase lengths,
// derived totals and the scan-phase encoding used by both raster FSMs.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_DIV      = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef enum logic [1:0] {
        ACT  = 2'd0,
        FP   = 2'd1,
        SYNC = 2'd2,
        BP   = 2'd3
    } phase_t;

    // Phase after a counter step, given the count value being stepped away from.
    function automatic phase_t next_phase(
        input phase_t           cur,
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] end_act,
        input logic [CNT_W-1:0] end_fp,
        input logic [CNT_W-1:0] end_sync,
        input logic [CNT_W-1:0] end_bp
    );
        phase_t nxt;
        nxt = cur;
        case (cur)
            ACT:     if (cnt == end_act)  nxt = FP;
            FP:      if (cnt == end_fp)   nxt = SYNC;
            SYNC:    if (cnt == end_sync) nxt = BP;
            default: if (cnt == end_bp)   nxt = ACT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel clock-enable: registered one-clk pulse every DIV enabled clocks, first one DIV clks after reset.
// en low freezes the divider phase and masks the pulse; no backpressure beyond that.
module pix_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pix_en
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else if (en) begin
            pix_en  <= (div_cnt == LAST);
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + CW'(1);
        end else begin
            pix_en  <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster scheduler: pixel/line counters with H and V phase FSMs; all outputs are registers or decodes of them.
// Counters step on the edge after each pix_en pulse; en low holds every counter and masks all strobes.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int DIV      = DEF_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last count of each phase; stepping off it moves the FSM on.
    localparam logic [CNT_W-1:0] H_END_ACT  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_END_FP   = CNT_W'(H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] H_END_SYNC = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] H_END_BP   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_END_ACT  = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_END_FP   = CNT_W'(V_ACTIVE + V_FP - 1);
    localparam logic [CNT_W-1:0] V_END_SYNC = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] V_END_BP   = CNT_W'(V_TOTAL - 1);

    phase_t h_phase;
    phase_t v_phase;
    logic   step;
    logic   line_end;
    logic   frame_end;

    pix_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .pix_en (pix_en)
    );

    // A pulse seen while en is low is not consumed, so a freeze never advances the raster.
    assign step      = pix_en & en;
    assign line_end  = step & (x == H_END_BP);
    assign frame_end = line_end & (y == V_END_BP);

    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            h_phase     <= ACT;
            v_phase     <= ACT;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= line_end;
            frame_start <= frame_end;
            if (step) begin
                x       <= line_end ? '0 : x + CNT_W'(1);
                h_phase <= next_phase(h_phase, x, H_END_ACT, H_END_FP, H_END_SYNC, H_END_BP);
            end
            if (line_end) begin
                y       <= frame_end ? '0 : y + CNT_W'(1);
                v_phase <= next_phase(v_phase, y, V_END_ACT, V_END_FP, V_END_SYNC, V_END_BP);
            end
        end
    end

    assign hsync    = (h_phase != SYNC);
    assign vsync    = (v_phase != SYNC);
    assign video_on = (h_phase == ACT) && (v_phase == ACT);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default-timing instance and a small-raster instance share clk/rst/en,
// each compared every cycle against a count-based reference, plus directed raster checks.
module tb_vga_timing_ctrl;
    import vga_pkg::*;

    typedef struct packed {
        logic       pix_en;
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic [9:0] x;
        logic [9:0] y;
        logic       line_start;
        logic       frame_start;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    logic       pe0, hs0, vs0, vo0, ls0, fs0;
    logic [9:0] x0, y0;
    logic       pe1, hs1, vs1, vo1, ls1, fs1;
    logic [9:0] x1, y1;

    vga_timing_ctrl u_dflt (
        .clk(clk), .rst(rst), .en(en), .pix_en(pe0), .hsync(hs0), .vsync(vs0),
        .video_on(vo0), .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_ctrl #(
        .DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .clk(clk), .rst(rst), .en(en), .pix_en(pe1), .hsync(hs1), .vsync(vs1),
        .video_on(vo1), .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
    );

    // Index 0 = default 640x480 timing, index 1 = small raster (15 x 11 pixels, 330 clks/frame).
    int cdiv[2] = '{4, 2};
    int cha[2]  = '{640, 8};
    int chf[2]  = '{16, 2};
    int chs[2]  = '{96, 3};
    int chb[2]  = '{48, 2};
    int cva[2]  = '{480, 6};
    int cvf[2]  = '{10, 2};
    int cvs[2]  = '{2, 2};
    int cvb[2]  = '{33, 1};

    int mdc[2];
    int mx[2];
    int my[2];
    bit mpe[2];
    bit mls[2];
    bit mfs[2];

    out_t q0[$];
    out_t q1[$];

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pe0_cnt, ls0_cnt, hs0_low, pe1_cnt, fs1_cnt, vs1_low, fs1_last, fs1_period;
    int en_edges1, gap1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counters();
        pe0_cnt = 0; ls0_cnt = 0; hs0_low = 0; pe1_cnt = 0;
        fs1_cnt = 0; vs1_low = 0; fs1_last = 0; fs1_period = 0;
        en_edges1 = 0; gap1 = 0;
    endtask

    // Reference raster: integer counters, phases decoded from the count ranges.
    task automatic model(input int i, output out_t e);
        int  ht, vt, hs_lo, vs_lo;
        bit  stp;
        ht = cha[i] + chf[i] + chs[i] + chb[i];
        vt = cva[i] + cvf[i] + cvs[i] + cvb[i];
        if (rst) begin
            mdc[i] = 0; mx[i] = 0; my[i] = 0; mpe[i] = 0; mls[i] = 0; mfs[i] = 0;
        end else if (en) begin
            stp    = mpe[i];
            mls[i] = 0;
            mfs[i] = 0;
            mpe[i] = (mdc[i] == cdiv[i] - 1);
            mdc[i] = (mdc[i] + 1) % cdiv[i];
            if (stp) begin
                mx[i]++;
                if (mx[i] == ht) begin
                    mx[i] = 0; mls[i] = 1; my[i]++;
                    if (my[i] == vt) begin
                        my[i] = 0; mfs[i] = 1;
                    end
                end
            end
        end else begin
            mpe[i] = 0; mls[i] = 0; mfs[i] = 0;
        end
        hs_lo = cha[i] + chf[i];
        vs_lo = cva[i] + cvf[i];
        e.pix_en      = mpe[i];
        e.hsync       = !(mx[i] >= hs_lo && mx[i] < hs_lo + chs[i]);
        e.vsync       = !(my[i] >= vs_lo && my[i] < vs_lo + cvs[i]);
        e.video_on    = (mx[i] < cha[i]) && (my[i] < cva[i]);
        e.x           = 10'(mx[i]);
        e.y           = 10'(my[i]);
        e.line_start  = mls[i];
        e.frame_start = mfs[i];
    endtask

    function automatic out_t snap0();
        out_t s;
        s = {pe0, hs0, vs0, vo0, x0, y0, ls0, fs0};
        return s;
    endfunction

    function automatic out_t snap1();
        out_t s;
        s = {pe1, hs1, vs1, vo1, x1, y1, ls1, fs1};
        return s;
    endfunction

    task automatic cycle();
        out_t e, a;
        model(0, e); q0.push_back(e);
        model(1, e); q1.push_back(e);
        @(posedge clk);
        if (rst) en_edges1 = 0;
        else if (en) en_edges1++;
        #1;
        cyc++;
        a = snap0(); e = q0.pop_front();
        check($sformatf("d0_cyc%0d", cyc), 32'(a), 32'(e));
        a = snap1(); e = q1.pop_front();
        check($sformatf("d1_cyc%0d", cyc), 32'(a), 32'(e));
        if (pe0) pe0_cnt++;
        if (ls0) ls0_cnt++;
        if (!hs0) hs0_low++;
        if (pe1) begin
            pe1_cnt++;
            gap1 = en_edges1;
            en_edges1 = 0;
        end
        if (!vs1) vs1_low++;
        if (fs1) begin
            fs1_cnt++;
            if (fs1_last > 0) fs1_period = cyc - fs1_last;
            fs1_last = cyc;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) cycle();
    endtask

    initial begin
        out_t rexp, s1;
        int   hx, hy, base;
        bit   found;

        rexp.pix_en = 1'b0; rexp.hsync = 1'b1; rexp.vsync = 1'b1; rexp.video_on = 1'b1;
        rexp.x = '0; rexp.y = '0; rexp.line_start = 1'b0; rexp.frame_start = 1'b0;

        rst = 1'b1; en = 1'b1;
        repeat (3) cycle();
        check("reset_d0", 32'(snap0()), 32'(rexp));
        check("reset_d1", 32'(snap1()), 32'(rexp));

        // Default timing: first line after reset release.
        rst = 1'b0; clear_counters(); cyc = 0;
        run_to(3);
        check("no_pe_before_clk4", 32'(pe0), 32'(0));
        run_to(4);
        check("first_pe_clk4", 32'(pe0), 32'(1));
        check("first_pe_x0", 32'(x0), 32'(0));
        run_to(5);
        check("x1_after_first_pe", 32'(x0), 32'(1));
        run_to(2560);
        check("x639_at_2560", 32'(x0), 32'(639));
        check("pe_at_2560", 32'(pe0), 32'(1));
        check("video_on_x639", 32'(vo0), 32'(1));
        run_to(2561);
        check("video_off_x640", 32'(vo0), 32'(0));
        run_to(3201);
        check("line_start_wrap", 32'(ls0), 32'(1));
        check("wrap_xy", 32'({x0, y0}), 32'({10'd0, 10'd1}));
        check("pe_count_line", 32'(pe0_cnt), 32'(800));
        check("line_start_count", 32'(ls0_cnt), 32'(1));
        check("hsync_low_clks", 32'(hs0_low), 32'(384));

        // Small raster: full frames.
        rst = 1'b1; cycle();
        rst = 1'b0; clear_counters(); cyc = 0;
        run_to(2);
        check("small_first_pe", 32'(pe1), 32'(1));
        run_to(331);
        check("small_frame_start", 32'({fs1, ls1}), 32'(2'b11));
        check("small_frame_xy", 32'({x1, y1}), 32'(0));
        run_to(661);
        check("small_fs_count", 32'(fs1_cnt), 32'(2));
        check("small_fs_period", 32'(fs1_period), 32'(330));
        check("small_vsync_low", 32'(vs1_low), 32'(120));

        // Freeze mid-frame at x=5, y=3.
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            if (x1 == 10'd5 && y1 == 10'd3) found = 1'b1;
            else cycle();
        end
        check("reach_x5_y3", 32'(found), 32'(1));
        hx = int'(x1); hy = int'(y1); s1 = snap1();
        base = pe0_cnt + pe1_cnt;
        en = 1'b0;
        repeat (37) cycle();
        check("freeze_no_pulses", 32'(pe0_cnt + pe1_cnt - base), 32'(0));
        check("freeze_xy", 32'({x1, y1}), 32'({10'(hx), 10'(hy)}));
        check("freeze_levels", 32'({hs1, vs1, vo1}), 32'({s1.hsync, s1.vsync, s1.video_on}));
        en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            if (pe1) found = 1'b1;
        end
        check("reenable_pulse", 32'(found), 32'(1));
        check("reenable_phase_gap", 32'(gap1), 32'(2));
        check("reenable_x_held", 32'(x1), 32'(hx));
        cycle();
        check("reenable_x_step", 32'(x1), 32'(hx + 1));

        // Reset inside hsync and vsync, with a pulse due on the next edge.
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            if (x1 == 10'd11 && y1 == 10'd9) found = 1'b1;
            else cycle();
        end
        check("reach_x11_y9", 32'(found), 32'(1));
        check("in_both_syncs", 32'({hs1, vs1}), 32'(0));
        rst = 1'b1;
        cycle();
        check("midframe_reset_d1", 32'(snap1()), 32'(rexp));
        check("midframe_reset_d0", 32'(snap0()), 32'(rexp));
        rst = 1'b0;
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
